// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl
//
// Instruction-side memory responder. Accepts req/gnt/rvalid fetches from the
// core, reads a single-port synchronous SRAM (one-cycle latency), optionally
// stretches the response by WAIT_STATES cycles, and returns data with inverted
// Hsiao (39,32) integrity bits. Fetches outside [MEM_BASE, MEM_BASE+4*MEM_WORDS)
// are answered with a bus error and zero data, without touching the SRAM.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   instr_req_i         fetch request
//   instr_addr_i        fetch byte address (bits [1:0] ignored)
//   instr_gnt_o         request accepted this cycle
//   instr_rvalid_o      response valid (one per grant)
//   instr_rdata_o       response data (0 on error and outside responses)
//   instr_rdata_intg_o  integrity bits of instr_rdata_o
//   instr_err_o         bus error, qualified by instr_rvalid_o
//   mem_req_o           SRAM read enable
//   mem_addr_o          SRAM word index
//   mem_rdata_i         SRAM read data, valid the cycle after mem_req_o
//   fetch_count_o       wrapping count of completed responses
module instr_mem_ctrl #(
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic [6:0]                   instr_rdata_intg_o,
  output logic                         instr_err_o,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic [31:0]                  fetch_count_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  // 33 bits so that a 4 GiB window would still compare correctly
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  wait_cnt_q;
  logic        err_q;
  logic [31:0] fetch_count_q;

  logic [31:0] offset;
  logic        in_range;
  logic        can_accept;
  logic        grant;

  // Inverted Hsiao (39,32) SECDED check bits; the final XOR is the inversion
  // constant for bits [38:32], so an all-zero word yields 7'h2A.
  function automatic logic [6:0] secded_inv_39_32_intg(input logic [31:0] d);
    logic [6:0] p;
    p[0] = ^(d & 32'h2606_BD25);
    p[1] = ^(d & 32'hDEBA_8050);
    p[2] = ^(d & 32'h413D_89AA);
    p[3] = ^(d & 32'h3123_4ED1);
    p[4] = ^(d & 32'hC2C1_323B);
    p[5] = ^(d & 32'h2DCC_624C);
    p[6] = ^(d & 32'h9850_5586);
    return p ^ 7'h2A;
  endfunction

  // A negative offset wraps to a large unsigned value and therefore fails the
  // range compare, which is exactly the out-of-range behaviour we want.
  assign offset     = instr_addr_i - MEM_BASE;
  assign in_range   = {1'b0, offset} < MEM_BYTES;
  assign can_accept = (state_q == IDLE) || (state_q == RESP);
  // Gating with rst keeps grant (and hence mem_req) low during reset even
  // though the FSM already sits in IDLE.
  assign grant      = rst && instr_req_i && can_accept;

  assign instr_gnt_o   = grant;
  assign mem_req_o     = grant && in_range;
  assign mem_addr_o    = offset[IDX_W+1:2];
  assign fetch_count_o = fetch_count_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A grant in RESP restarts the transaction immediately,
  // giving one fetch per cycle when WAIT_STATES is 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant) begin
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-transaction bookkeeping and the completed-response counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q    <= 3'd0;
      err_q         <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      if (grant) begin
        err_q      <= !in_range;
        wait_cnt_q <= WAIT_LOAD;
      end else if ((state_q == WAIT) && (wait_cnt_q != 3'd0)) begin
        wait_cnt_q <= wait_cnt_q - 3'd1;
      end
      if (state_q == RESP) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  // Response outputs. mem_rdata_i still holds the word for this fetch during
  // RESP because a new read only updates it on the following edge.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = 32'd0;
    if (state_q == RESP) begin
      instr_rvalid_o = 1'b1;
      instr_err_o    = err_q;
      instr_rdata_o  = err_q ? 32'd0 : mem_rdata_i;
    end
    instr_rdata_intg_o = secded_inv_39_32_intg(instr_rdata_o);
  end

endmodule
